// File: rtl/vtg_pkg.sv
// Shared definitions for the skid-buffered register pipeline:
// slice state encoding and sizing helpers.
package vtg_pkg;

  // Bit 1 is the skid-valid flag, so a slice's in_ready is a plain flop output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } slice_state_t;

  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

  function automatic logic [1:0] occupancy(input slice_state_t s);
    return (s == FULL2) ? 2'd2 : ((s == FULL1) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/vtg_reg_slice.sv
// One full-throughput register slice with a skid buffer. Both in_ready and
// out_valid/out_data come straight from flops, so no combinational path crosses it.
//
// Handshake: a word moves when valid && ready are both high at a rising edge;
// valid never waits for ready, and data is stable while valid is high and not taken.
module vtg_reg_slice
  import vtg_pkg::*;
#(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  output slice_state_t    state
);

  slice_state_t    state_q, state_d;
  logic [SIZE-1:0] m_d, s_d;
  logic            push, pop;
  logic            load_main, main_from_skid, load_skid;

  assign in_ready  = ~state_q[1];
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_d;
  assign state     = state_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_d     <= RST_VAL;
      s_d     <= RST_VAL;
    end else begin
      state_q <= state_d;
      if (load_main) m_d <= main_from_skid ? s_d : in_data;
      if (load_skid) s_d <= in_data;
    end
  end

  // Flush only clears the valid state; data registers keep whatever they held.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            load_main = 1'b1;
            state_d   = FULL1;
          end
        end
        FULL1: begin
          if (push && pop) begin
            load_main = 1'b1;
          end else if (push) begin
            load_skid = 1'b1;
            state_d   = FULL2;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL2: begin
          if (pop) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = FULL1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/vtg_pipe_register.sv
// DEPTH-stage valid/ready register pipeline built from skid-buffered slices,
// with a synchronous flush and a registered occupancy count.
module vtg_pipe_register
  import vtg_pkg::*;
#(
  parameter int              SIZE    = 8,
  parameter int              DEPTH   = 2,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SIZE-1:0]               in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SIZE-1:0]               out_data,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("vtg_pipe_register: DEPTH must be at least 1");
  end

  logic [DEPTH:0]  vld, rdy;
  logic [SIZE-1:0] dat [DEPTH+1];
  slice_state_t    st  [DEPTH];
  logic [CW-1:0]   held;
  logic            push, pop;

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;
  assign in_ready   = rdy[0];
  assign out_valid  = vld[DEPTH];
  assign out_data   = dat[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    vtg_reg_slice #(
      .SIZE   (SIZE),
      .RST_VAL(RST_VAL)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_data (dat[k+1]),
      .state    (st[k])
    );
  end

  // Internal slice-to-slice moves conserve words, so only the end handshakes matter.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else              count <= count + CW'(push) - CW'(pop);
  end

  always_comb begin
    held = '0;
    for (int k = 0; k < DEPTH; k++) held = held + CW'(occupancy(st[k]));
  end

  count_matches_held: assert property (@(posedge clk) disable iff (rst) count == held);

endmodule

// File: doc/vtg_pipe_register.md
Name: vtg_pipe_register

Overview:
- Parametrised successor to the single-stage enable register: a DEPTH-stage valid/ready register pipeline of arbitrary width and reset value.
- Every stage is a full-throughput slice with a skid buffer, so backpressure is fully registered and never forms a combinational path across the pipeline.
- Used to cut timing paths between streaming blocks.
- Adds flush and an occupancy count.

Parameters:
- SIZE, 8, data width in bits (>=1)
- DEPTH, 2, number of register slices (>=1; 0 is illegal and must fail elaboration)
- RST_VAL, 0, value loaded into all data registers on reset

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of all valid state, data untouched
- in_valid  in  1  upstream data valid
- in_ready  out  1  pipeline can accept (registered)
- in_data  in  SIZE  upstream data
- out_valid  out  1  downstream data valid (registered)
- out_ready  in  1  downstream accepts
- out_data  out  SIZE  downstream data (registered)
- count  out  $clog2(2*DEPTH+1)  words currently held, 0..2*DEPTH

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Data is never dropped or duplicated except by flush or reset.
- Reset (rst=1):
  - All valid/skid flags clear.
  - All data registers load RST_VAL.
  - in_ready=1, out_valid=0, out_data=RST_VAL, count=0 on the cycle after.
  - rst dominates flush and all handshakes.
- Slice state machine, per stage. Each slice has a main register (m_v, m_d) and a skid register (s_v, s_d).
  - EMPTY (m_v=0, s_v=0):
    - accept goes to main -> FULL1.
  - FULL1 (m_v=1, s_v=0):
    - push, no pop: data goes to skid -> FULL2.
    - push and pop: main reloads -> FULL1.
    - pop, no push -> EMPTY.
  - FULL2 (m_v=1, s_v=1):
    - slice in_ready=0.
    - pop: skid moves to main -> FULL1.
    - No push is possible in this state.
  - Slice in_ready = !s_v, a registered value.
  - Slice output = main register.
- Latency: a word accepted in cycle N appears on out_data/out_valid in cycle N+DEPTH when no backpressure is applied.
- Throughput: one word per cycle sustained while out_ready=1.
- in_ready deassertion timing:
  - in_ready deasserts no earlier than the cycle after the first slice's skid fills.
  - The pipeline absorbs up to 2*DEPTH words with out_ready held low from empty.
- Ordering: strict FIFO order end to end.
- flush=1 (and rst=0):
  - All m_v/s_v clear at the next edge.
  - Any input transfer in the same cycle is discarded.
  - Any output transfer in the same cycle still counts as consumed by downstream.
  - Next cycle: out_valid=0, in_ready=1, count=0.
  - Data registers hold their old values.
- count:
  - Registered.
  - Updates as count + push - pop, where push/pop are the input/output transfers in the current cycle.
  - Simultaneous push and pop leaves it unchanged.
  - Cleared by flush/rst.
  - Must always equal the sum of m_v+s_v across all slices.
- out_data when out_valid=0 is don't-care for checking, but must equal RST_VAL after reset.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Decomposition:
- Shared package vtg_pkg holds:
  - Slice state encoding: localparams EMPTY=2'd0, FULL1=2'd1, FULL2=2'd2 (or derived from m_v/s_v).
  - A helper function for count width.
- Natural sub-module: vtg_reg_slice (SIZE, RST_VAL). One skid-buffered stage with the same handshake ports plus flush.
- vtg_pipe_register instantiates DEPTH slices with a generate loop and owns the count register.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, out_data=RST_VAL (e.g. 8'hA5), count=0.
- DEPTH=3, out_ready=1, stream 0x01..0x10 one per cycle:
  - 0x01 appears 3 cycles after acceptance.
  - One output every cycle, order preserved.
  - count steady at 3.
- DEPTH=2, out_ready=0, in_valid held with 0x11,0x22,...:
  - Exactly 4 words accepted, then in_ready=0.
  - count=4.
  - Raise out_ready: 0x11,0x22,0x33,0x44 emerge on consecutive cycles.
- Random in_valid/out_ready at 50% for 10k words -> scoreboard matches exactly, count invariant holds every cycle.
- Fill with 3 words, assert flush together with in_valid=1 (0x77):
  - Next cycle out_valid=0, count=0.
  - 0x77 never appears.
  - Subsequent 0x88 emerges after DEPTH cycles.
- Assert rst mid-stream with count=3 and flush=1 -> next cycle all outputs at reset values, out_data=RST_VAL.
